// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit holding registers, round-robin grant onto a registered CDB.
// Optional macro CDB_BYPASS_EN lets a result skip its holding register when all holds are empty.
module cdb_arbiter #(
    parameter int NUM_FU = 3,
    parameter int TAG_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic                     CLOCK_50,
    input  logic                     RSTN_N,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*DATA_W-1:0] fu_result,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic                     busy
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Handshake: a unit's result transfers at a rising edge where fu_valid[i] and
    // fu_ready[i] are both high; the unit keeps valid and data stable until then.
    // The CDB side has no ready: every cdb_valid pulse must be consumed.

    logic [NUM_FU-1:0] hold_valid;
    logic [NUM_FU-1:0] hold_valid_nxt;
    logic [DATA_W-1:0] hold_data [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_ptr_nxt;

    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] capture;
    logic              bypass;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [DATA_W-1:0] win_data;

    assign fu_ready = ~hold_valid;
    assign busy     = |hold_valid;

    // Bypass only when nothing is waiting, so older held results are never overtaken.
    always_comb begin
`ifdef CDB_BYPASS_EN
        bypass = (hold_valid == '0) && !flush;
`else
        bypass = 1'b0;
`endif
        req = bypass ? fu_valid : hold_valid;
    end

    // Round-robin search starting at rr_ptr, wrapping at NUM_FU.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            cand = PTR_W'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_data   = bypass ? fu_result[win_idx*DATA_W +: DATA_W] : hold_data[win_idx];
        rr_ptr_nxt = (32'(win_idx) == NUM_FU - 1) ? '0 : win_idx + 1'b1;
    end

    // Capture needs an empty hold and grant needs a full one, so they never collide on a unit.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            capture[i] = fu_valid[i] && !hold_valid[i] &&
                         !(bypass && win_found && (win_idx == PTR_W'(i)));
        end
        hold_valid_nxt = hold_valid | capture;
        if (win_found && !bypass) hold_valid_nxt[win_idx] = 1'b0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RSTN_N) begin
            hold_valid <= '0;
            for (int i = 0; i < NUM_FU; i++) hold_data[i] <= '0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            rr_ptr     <= '0;
        end else if (flush) begin
            hold_valid <= '0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
        end else begin
            hold_valid <= hold_valid_nxt;
            for (int i = 0; i < NUM_FU; i++) begin
                if (capture[i]) hold_data[i] <= fu_result[i*DATA_W +: DATA_W];
            end
            cdb_valid <= win_found;
            cdb_tag   <= win_found ? TAG_W'(32'(win_idx) + 1) : '0;
            cdb_data  <= win_found ? win_data : '0;
            if (win_found) rr_ptr <= rr_ptr_nxt;
        end
    end

endmodule
